// File: rtl/exhaustive_stim_gen_if.sv
// rtl/exhaustive_stim_gen_if.sv - control, stimulus and signature bundle of the exhaustive stimulus generator
interface exhaustive_stim_gen_if #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 3,
    parameter int SIG_W = 16
);
    logic             start;
    logic [1:0]       mode;
    logic [OUT_W-1:0] resp;
    logic [IN_W-1:0]  stim;
    logic             stim_valid;
    logic [IN_W-1:0]  vec_idx;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] signature;

    modport master (
        input  start, mode, resp,
        output stim, stim_valid, vec_idx, busy, done, signature
    );

    modport slave (
        output start, mode, resp,
        input  stim, stim_valid, vec_idx, busy, done, signature
    );
endinterface

// File: rtl/exhaustive_stim_gen.sv
// rtl/exhaustive_stim_gen.sv - sweeps every IN_W-bit vector in up/down/Gray order and folds responses into a MISR
module exhaustive_stim_gen #(
    parameter int               IN_W  = 3,
    parameter int               OUT_W = 3,
    parameter int               HOLD  = 1,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = '0
) (
    input logic                   clk,
    input logic                   reset,
    exhaustive_stim_gen_if.master bus
);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [IN_W-1:0] LAST_IDX  = {IN_W{1'b1}};
    localparam logic [HW-1:0]   LAST_HOLD = HW'(HOLD - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [IN_W-1:0]  vec_idx;
    logic [HW-1:0]    hold_cnt;
    logic [1:0]       mode_q;
    logic [SIG_W-1:0] signature;
    logic [SIG_W-1:0] sig_nx;
    logic             start_ok;
    logic             sample;
    logic             last;

    assign start_ok = bus.start && (state != S_RUN);
    assign sample   = (state == S_RUN) && (hold_cnt == LAST_HOLD);
    assign last     = (vec_idx == LAST_IDX);
    assign sig_nx   = {signature[SIG_W-2:0], 1'b0}
                    ^ (signature[SIG_W-1] ? POLY : '0)
                    ^ SIG_W'(bus.resp);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            vec_idx   <= '0;
            hold_cnt  <= '0;
            mode_q    <= 2'b00;
            signature <= SEED;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                mode_q    <= bus.mode;
                vec_idx   <= '0;
                hold_cnt  <= '0;
                signature <= SEED;
            end else if (state == S_RUN) begin
                if (sample) begin
                    signature <= sig_nx;
                    // The final vector is not advanced so vec_idx never wraps within a sweep
                    if (!last) begin
                        vec_idx  <= vec_idx + 1'b1;
                        hold_cnt <= '0;
                    end
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start) state_nx = S_RUN;
            S_RUN:   if (sample && last) state_nx = S_DONE;
            S_DONE:  if (bus.start) state_nx = S_RUN;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = (state == S_RUN);
        bus.stim_valid = (state == S_RUN);
        bus.done       = (state == S_DONE);
        bus.vec_idx    = vec_idx;
        bus.signature  = signature;
        bus.stim       = '0;
        if (state == S_RUN) begin
            case (mode_q)
                2'b01:   bus.stim = ~vec_idx;
                2'b10:   bus.stim = vec_idx ^ (vec_idx >> 1);
                default: bus.stim = vec_idx;
            endcase
        end
    end
endmodule

// File: tb/tb_exhaustive_stim_gen.sv
// tb/tb_exhaustive_stim_gen.sv - directed self-checking bench for exhaustive_stim_gen
module tb_exhaustive_stim_gen;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    exhaustive_stim_gen_if #(.IN_W(3), .OUT_W(3), .SIG_W(16)) sif ();
    exhaustive_stim_gen_if #(.IN_W(3), .OUT_W(3), .SIG_W(16)) sif2 ();

    assign sif.resp  = sif.stim;
    assign sif2.resp = sif2.stim;

    exhaustive_stim_gen #(.IN_W(3), .OUT_W(3), .HOLD(1), .SIG_W(16), .POLY(16'h1021), .SEED(16'h0000)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.master)
    );

    exhaustive_stim_gen #(.IN_W(3), .OUT_W(3), .HOLD(2), .SIG_W(16), .POLY(16'h1021), .SEED(16'h0000)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (sif2.master)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_done(input string tag, input logic [15:0] sig);
        check({tag, "_done"},  32'(sif.done), 32'd1);
        check({tag, "_busy0"}, 32'(sif.busy), 32'd0);
        check({tag, "_val0"},  32'(sif.stim_valid), 32'd0);
        check({tag, "_stim0"}, 32'(sif.stim), 32'd0);
        check({tag, "_sig"},   32'(sif.signature), 32'(sig));
    endtask

    // e packs the eight expected stim values, first vector in the top bits
    task automatic sweep(input logic [1:0] m, input logic [23:0] e, input logic [15:0] sig, input string tag);
        sif.mode  = m;
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check({tag, "_stim"}, 32'(sif.stim), 32'(e[23-3*i -: 3]));
            check({tag, "_idx"},  32'(sif.vec_idx), 32'(i));
            check({tag, "_val"},  32'(sif.stim_valid), 32'd1);
            check({tag, "_busy"}, 32'(sif.busy), 32'd1);
            check({tag, "_done0"}, 32'(sif.done), 32'd0);
            tick();
        end
        check_done(tag, sig);
    endtask

    localparam logic [23:0] SEQ_UP   = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    localparam logic [23:0] SEQ_DOWN = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [23:0] SEQ_GRAY = {3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

    initial begin
        logic [31:0] sig_steps;
        sif.start  = 1'b0;
        sif.mode   = 2'b00;
        sif2.start = 1'b0;
        sif2.mode  = 2'b00;
        reset      = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("rst_stim",  32'(sif.stim), 32'd0);
        check("rst_idx",   32'(sif.vec_idx), 32'd0);
        check("rst_val",   32'(sif.stim_valid), 32'd0);
        check("rst_busy",  32'(sif.busy), 32'd0);
        check("rst_done",  32'(sif.done), 32'd0);
        check("rst_sig",   32'(sif.signature), 32'h0000);
        check("rst2_busy", 32'(sif2.busy), 32'd0);
        check("rst2_sig",  32'(sif2.signature), 32'h0000);

        sweep(2'b00, SEQ_UP, 16'h000F, "up");
        tick();
        tick();
        check("done_sticky", 32'(sif.done), 32'd1);
        check("sig_stable",  32'(sif.signature), 32'h000F);
        sweep(2'b00, SEQ_UP, 16'h000F, "up_again");
        sweep(2'b10, SEQ_GRAY, 16'h0022, "gray");
        sweep(2'b01, SEQ_DOWN, 16'h02F2, "down");
        sweep(2'b11, SEQ_UP, 16'h000F, "mode3");

        // reset during the fourth RUN cycle
        sif.mode  = 2'b00;
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        tick();
        tick();
        tick();
        check("mid_idx3", 32'(sif.vec_idx), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_stim", 32'(sif.stim), 32'd0);
        check("mrst_busy", 32'(sif.busy), 32'd0);
        check("mrst_done", 32'(sif.done), 32'd0);
        check("mrst_val",  32'(sif.stim_valid), 32'd0);
        check("mrst_sig",  32'(sif.signature), 32'h0000);
        tick();
        check("idle_stays", 32'(sif.busy), 32'd0);
        sweep(2'b00, SEQ_UP, 16'h000F, "after_rst");

        // start and a mode change during RUN must not disturb the sweep
        sif.mode  = 2'b00;
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        tick();
        tick();
        check("ign_idx2", 32'(sif.vec_idx), 32'd2);
        sif.start = 1'b1;
        sif.mode  = 2'b10;
        tick();
        sif.start = 1'b0;
        check("ign_stim3", 32'(sif.stim), 32'd3);
        check("ign_idx3",  32'(sif.vec_idx), 32'd3);
        tick();
        tick();
        tick();
        tick();
        check("ign_stim7", 32'(sif.stim), 32'd7);
        check("ign_busy7", 32'(sif.busy), 32'd1);
        tick();
        check_done("ign", 16'h000F);
        sweep(2'b10, SEQ_GRAY, 16'h0022, "gray_restart");

        // start held high: DONE lasts one cycle then a new sweep begins
        sif.mode  = 2'b00;
        sif.start = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) tick();
        check("cont_done", 32'(sif.done), 32'd1);
        check("cont_busy0", 32'(sif.busy), 32'd0);
        tick();
        check("cont_busy", 32'(sif.busy), 32'd1);
        check("cont_done0", 32'(sif.done), 32'd0);
        check("cont_idx0", 32'(sif.vec_idx), 32'd0);
        check("cont_sig0", 32'(sif.signature), 32'h0000);
        sif.start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("cont_idx7", 32'(sif.vec_idx), 32'd7);
        tick();
        check_done("cont", 16'h000F);

        // HOLD=2: each vector twice, signature advances only on the second cycle
        sig_steps  = 32'h0010_3214;
        sif2.mode  = 2'b00;
        sif2.start = 1'b1;
        tick();
        sif2.start = 1'b0;
        for (int j = 0; j < 16; j++) begin
            check("h2_stim", 32'(sif2.stim), 32'(j / 2));
            check("h2_busy", 32'(sif2.busy), 32'd1);
            check("h2_sig",  32'(sif2.signature), 32'(sig_steps[31-4*(j/2) -: 4]));
            tick();
        end
        check("h2_done", 32'(sif2.done), 32'd1);
        check("h2_busy0", 32'(sif2.busy), 32'd0);
        check("h2_sigF", 32'(sif2.signature), 32'h000F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/exhaustive_stim_gen.md
Name: exhaustive_stim_gen

Overview:
- Synthesizable, parametrised exhaustive stimulus generator for small combinational DUTs.
- Sweeps every IN_W-bit input combination in a selectable order (binary up, binary down, Gray) and holds each vector for HOLD cycles.
- On the last hold cycle of each vector it samples the DUT response into a MISR signature.
- Used in self-checking benches and on-chip BIST of small logic blocks; replaces the hand-toggled per-bit input clocks used so far.

Parameters:
- IN_W, 3, stimulus width; sweep length is 2^IN_W vectors (1..16).
- OUT_W, 3, DUT response width; must be <= SIG_W.
- HOLD, 1, cycles each vector is held (>= 1).
- SIG_W, 16, signature register width.
- POLY, 16'h1021, MISR feedback polynomial (SIG_W bits).
- SEED, 0, signature value loaded at start.

Ports:
- clk  in  1  system clock, all state on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled in IDLE or DONE only.
- mode  in  2  order: 00 binary up, 01 binary down, 10 Gray up, 11 treated as 00; latched at start.
- resp  in  OUT_W  DUT response to the current stim.
- stim  out  IN_W  vector driven to the DUT.
- stim_valid  out  1  high while stim carries a sweep vector.
- vec_idx  out  IN_W  ordinal of the current vector (0 .. 2^IN_W-1).
- busy  out  1  high in RUN.
- done  out  1  sweep complete; sticky until the next start or reset.
- signature  out  SIG_W  MISR contents.

Behaviour:
- Reset is synchronous and active-high. Reset values:
  - state IDLE.
  - stim, vec_idx, hold_cnt all 0.
  - stim_valid, busy, done all 0.
  - signature = SEED.
- States and transitions:
  - IDLE -> RUN when start=1.
  - RUN -> DONE after the final sample.
  - DONE -> RUN when start=1.
  - Reset from any state -> IDLE, including mid-sweep; no partial signature is kept.
- Actions on start (IDLE or DONE): latch mode; vec_idx=0, hold_cnt=0, signature=SEED, done=0.
- Latency: start sampled at edge k; stim_valid=1 and first vector on stim from edge k+1.
- stim mapping, combinational from registered vec_idx and latched mode:
  - binary up: stim = vec_idx.
  - binary down: stim = ~vec_idx.
  - Gray: stim = vec_idx ^ (vec_idx >> 1).
  - stim = 0 whenever not in RUN.
- Hold counting in RUN: hold_cnt counts 0..HOLD-1.
  - On hold_cnt == HOLD-1, sample resp into the MISR.
  - If vec_idx == 2^IN_W-1: go to DONE, done=1, busy=0, stim_valid=0.
  - Otherwise: vec_idx++, hold_cnt=0.
- Timing: RUN lasts exactly 2^IN_W * HOLD cycles; done rises on the cycle after the last sample.
- MISR update: sig_next = (sig << 1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_extend(resp), truncated to SIG_W.
  - Updates only on sample cycles.
  - signature is stable in DONE and IDLE.
- Boundaries:
  - start while in RUN is ignored; mode changes during RUN are ignored.
  - start held high continuously restarts the sweep every time DONE is reached; DONE lasts 1 cycle.
  - No wrap of vec_idx past 2^IN_W-1 within a sweep.
  - HOLD=1: every RUN cycle is a sample cycle.

Test Plan:
- IN_W=3, HOLD=1, mode=00, pulse start at cycle 0 -> stim 0,1,2,...,7 on cycles 1..8, stim_valid=1 and busy=1 for exactly 8 cycles; done=1 from cycle 9 and held.
- mode=10 -> stim sequence 0,1,3,2,6,7,5,4; mode=01 -> 7,6,5,4,3,2,1,0; vec_idx 0..7 in both cases.
- HOLD=2, mode=00 -> each vector present 2 consecutive cycles, 16 RUN cycles, MISR updates only on odd RUN cycles.
- Signature: SEED=0, OUT_W=IN_W=3, resp looped back from stim, mode=00 -> signature=16'h000F in DONE; repeat sweep via start -> same 16'h000F.
- Assert reset at RUN cycle 4 -> next cycle state IDLE: stim=0, busy=0, done=0, signature=SEED; new start gives a full 8-vector sweep.
- start pulsed at RUN cycle 3 with mode=10 -> ignored, sweep stays binary up and ends at the original time; start in DONE restarts with the newly latched mode.
